// File: rtl/reg_pkg.sv
// Register-file geometry shared across the backend.
// Physical register count and datapath word width.
package reg_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int WORD_SIZE     = 32;
endpackage

// File: rtl/rob_pkg.sv
// Reorder-buffer geometry shared across the backend.
// ROB depth sets the width of every rob pointer.
package rob_pkg;
  localparam int ROB_ENTRIES = 32;
endpackage

// File: rtl/wb_pkg.sv
// Writeback request bundle carried from FUs to write ports.
// Field widths follow the regfile and ROB geometry.
package wb_pkg;
  localparam int DEST_W = $clog2(reg_pkg::NUM_PHYS_REGS);
  localparam int DATA_W = reg_pkg::WORD_SIZE;
  localparam int ROB_W  = $clog2(rob_pkg::ROB_ENTRIES);

  typedef struct packed {
    logic [DEST_W-1:0] dest_reg_phys;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_ptr;
    logic              has_dest;
  } wb_req_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// Per-FU skid FIFO absorbing writeback port contention.
// Flush empties it; push is pre-qualified by the caller.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_N_in,
  input  logic          flush_in,
  input  logic          push_in,
  input  wb_req_t       push_pkt_in,
  input  logic          pop_in,
  output logic [CW-1:0] count_out,
  output wb_req_t       head_out
);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  assign count_out = cnt;
  assign head_out  = mem[rd_ptr];

  // Storage array; contents need no reset, count gates use.
  always_ff @(posedge clk_in) begin
    if (push_in && !flush_in) begin
      mem[wr_ptr] <= push_pkt_in;
    end
  end

  // Pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_in) wr_ptr <= wr_ptr + 1'b1;
      if (pop_in)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_in) - CW'(pop_in);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_FU skid FIFOs share
// NUM_WB_PORTS registered write ports.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int SW = $clog2(NUM_FU),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic                                 flush_in,
  input  logic    [NUM_FU-1:0]                 fu_valid_in,
  input  wb_req_t [NUM_FU-1:0]                 fu_pkt_in,
  output logic    [NUM_FU-1:0]                 fu_ready_out,
  output logic    [NUM_WB_PORTS-1:0]           wr_valid_out,
  output logic    [NUM_WB_PORTS-1:0]           wr_en_out,
  output wb_req_t [NUM_WB_PORTS-1:0]           wr_pkt_out,
  output logic    [NUM_WB_PORTS-1:0][SW-1:0]   wr_src_out
);

  logic [CW-1:0] cnt [NUM_FU];
  wb_req_t       head [NUM_FU];
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] grant;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_next;
  logic [NUM_WB_PORTS-1:0]         gvld;
  logic [NUM_WB_PORTS-1:0][SW-1:0] gsrc;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // Ready comes from the registered count only.
    assign fu_ready_out[i] = cnt[i] < CW'(FIFO_DEPTH);
    assign push[i]         = fu_valid_in[i] & fu_ready_out[i];
    assign nonempty[i]     = cnt[i] != '0;

    wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in      (clk_in),
      .rst_N_in    (rst_N_in),
      .flush_in    (flush_in),
      .push_in     (push[i]),
      .push_pkt_in (fu_pkt_in[i]),
      .pop_in      (grant[i]),
      .count_out   (cnt[i]),
      .head_out    (head[i])
    );
  end

  // Scan from rr_ptr, grant non-empty heads to ports in order.
  always_comb begin : arb
    int n;
    int idx;
    int last;
    grant   = '0;
    gvld    = '0;
    gsrc    = '0;
    rr_next = rr_ptr;
    n       = 0;
    last    = 0;
    for (int s = 0; s < NUM_FU; s++) begin
      idx = int'(rr_ptr) + s;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (nonempty[idx] && n < NUM_WB_PORTS) begin
        grant[idx] = 1'b1;
        gvld[n]    = 1'b1;
        gsrc[n]    = SW'(idx);
        n          = n + 1;
        last       = idx;
      end
    end
    if (n != 0) begin
      rr_next = (last == NUM_FU - 1) ? '0 : SW'(last + 1);
    end
  end

  // Register granted heads onto the ports; flush clears all.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rr_ptr       <= '0;
      wr_valid_out <= '0;
      wr_en_out    <= '0;
      wr_pkt_out   <= '0;
      wr_src_out   <= '0;
    end else if (flush_in) begin
      rr_ptr       <= '0;
      wr_valid_out <= '0;
      wr_en_out    <= '0;
      wr_pkt_out   <= '0;
      wr_src_out   <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int k = 0; k < NUM_WB_PORTS; k++) begin
        wr_valid_out[k] <= gvld[k];
        wr_en_out[k]    <= gvld[k] & head[gsrc[k]].has_dest;
        wr_pkt_out[k]   <= gvld[k] ? head[gsrc[k]] : '0;
        wr_src_out[k]   <= gvld[k] ? gsrc[k] : '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-FU order board.
// Defaults: 4 FUs, 2 ports, depth 4.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int NF = 4;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     flush;
  logic    [NF-1:0]         fu_valid;
  wb_req_t [NF-1:0]         fu_pkt;
  logic    [NF-1:0]         fu_ready;
  logic    [NP-1:0]         wr_valid;
  logic    [NP-1:0]         wr_en;
  wb_req_t [NP-1:0]         wr_pkt;
  logic    [NP-1:0][1:0]    wr_src;

  wb_arbiter #(
    .NUM_FU(NF), .NUM_WB_PORTS(NP), .FIFO_DEPTH(4)
  ) dut (
    .clk_in       (clk),
    .rst_N_in     (rst_n),
    .flush_in     (flush),
    .fu_valid_in  (fu_valid),
    .fu_pkt_in    (fu_pkt),
    .fu_ready_out (fu_ready),
    .wr_valid_out (wr_valid),
    .wr_en_out    (wr_en),
    .wr_pkt_out   (wr_pkt),
    .wr_src_out   (wr_src)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic wb_req_t mk(input int d, input int dat,
                                 input int rob, input bit hd);
    wb_req_t r;
    r.dest_reg_phys = DEST_W'(d);
    r.data          = DATA_W'(dat);
    r.rob_ptr       = ROB_W'(rob);
    r.has_dest      = hd;
    return r;
  endfunction

  task automatic do_reset;
    fu_valid = '0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    tick();
  endtask

  logic [31:0] exp_d [NF][32];
  int wi [NF];
  int ri [NF];
  int outs;
  bit mon_en;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NP; k++) begin
        if (wr_valid[k]) begin
          int s;
          s = int'(wr_src[k]);
          chk("sb_avail", 64'(ri[s] < wi[s]), 64'd1);
          if (ri[s] < wi[s]) begin
            chk("sb_order", 64'(wr_pkt[k].data), 64'(exp_d[s][ri[s]]));
            ri[s]++;
            outs++;
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_pkt   = '0;
    mon_en   = 1'b0;
    outs     = 0;
    for (int f = 0; f < NF; f++) begin
      wi[f] = 0;
      ri[f] = 0;
    end
    tick();
    chk("rst_valid", 64'(wr_valid), 64'd0);
    chk("rst_en", 64'(wr_en), 64'd0);
    chk("rst_pkt0", 64'(wr_pkt[0]), 64'd0);
    chk("rst_src", 64'(wr_src), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'hF);
    rst_n = 1'b1;
    tick();

    // single result, one-cycle latency
    fu_pkt[0] = mk(5, 'hAA, 3, 1'b1);
    fu_valid  = 4'b0001;
    tick();
    fu_valid  = '0;
    chk("single_nobypass", 64'(wr_valid), 64'd0);
    tick();
    chk("single_valid", 64'(wr_valid), 64'b01);
    chk("single_en", 64'(wr_en), 64'b01);
    chk("single_dest", 64'(wr_pkt[0].dest_reg_phys), 64'd5);
    chk("single_data", 64'(wr_pkt[0].data), 64'hAA);
    chk("single_src", 64'(wr_src[0]), 64'd0);
    tick();
    chk("single_idle", 64'(wr_valid), 64'd0);

    // contention from rr_ptr=0
    do_reset();
    for (int f = 0; f < NF; f++) fu_pkt[f] = mk(f + 1, 'h10 + f, f, 1'b1);
    fu_valid = 4'hF;
    tick();
    fu_valid = '0;
    tick();
    chk("cont1_valid", 64'(wr_valid), 64'b11);
    chk("cont1_src", 64'(wr_src), 64'b0100);
    chk("cont1_data1", 64'(wr_pkt[1].data), 64'h11);
    chk("cont1_rr", 64'(dut.rr_ptr), 64'd2);
    tick();
    chk("cont2_valid", 64'(wr_valid), 64'b11);
    chk("cont2_src", 64'(wr_src), 64'b1110);
    chk("cont2_data0", 64'(wr_pkt[0].data), 64'h12);
    chk("cont2_rr", 64'(dut.rr_ptr), 64'd0);

    // store result without destination
    do_reset();
    fu_pkt[3] = mk(9, 'h77, 'h1B, 1'b0);
    fu_valid  = 4'b1000;
    tick();
    fu_valid  = '0;
    tick();
    chk("store_valid", 64'(wr_valid), 64'b01);
    chk("store_en", 64'(wr_en), 64'b00);
    chk("store_rob", 64'(wr_pkt[0].rob_ptr), 64'h1B);
    chk("store_src", 64'(wr_src[0]), 64'd3);

    // flush with concurrent push
    do_reset();
    fu_valid  = 4'b0010;
    fu_pkt[1] = mk(1, 'hA1, 1, 1'b1);
    tick();
    fu_pkt[1] = mk(2, 'hA2, 2, 1'b1);
    tick();
    fu_pkt[1] = mk(3, 'hA3, 3, 1'b1);
    tick();
    chk("flush_pre", 64'(wr_pkt[0].data), 64'hA2);
    fu_valid  = 4'b0001;
    fu_pkt[0] = mk(4, 'hB4, 4, 1'b1);
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    fu_valid  = '0;
    chk("flush_valid", 64'(wr_valid), 64'd0);
    chk("flush_ready", 64'(fu_ready), 64'hF);
    chk("flush_rr", 64'(dut.rr_ptr), 64'd0);
    tick();
    chk("flush_drop", 64'(wr_valid), 64'd0);

    // asynchronous reset with entries buffered
    do_reset();
    for (int f = 0; f < NF; f++) fu_pkt[f] = mk(f, 'h20 + f, f, 1'b1);
    fu_valid = 4'hF;
    tick();
    fu_valid = '0;
    tick();
    chk("areset_pre", 64'(wr_valid), 64'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(wr_valid), 64'd0);
    chk("areset_en", 64'(wr_en), 64'd0);
    chk("areset_pkt1", 64'(wr_pkt[1]), 64'd0);
    chk("areset_ready", 64'(fu_ready), 64'hF);
    #2 rst_n = 1'b1;
    fu_pkt[1] = mk(7, 'h55, 6, 1'b1);
    fu_valid  = 4'b0010;
    tick();
    fu_valid  = '0;
    tick();
    chk("areset_post_v", 64'(wr_valid), 64'b01);
    chk("areset_post_d", 64'(wr_pkt[0].data), 64'h55);
    chk("areset_post_s", 64'(wr_src[0]), 64'd1);
    tick();
    chk("areset_lost", 64'(wr_valid), 64'd0);

    // backpressure: all FUs stream, FU2 fills and holds
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int f = 0; f < NF; f++) begin
        fu_pkt[f] = mk(f, 32'hB000_0000 | (f << 8) | c, c, 1'b1);
        exp_d[f][wi[f]] = 32'hB000_0000 | (f << 8) | c;
        wi[f]++;
      end
      fu_valid = 4'hF;
      tick();
      if (c == 4) chk("bp_ready_e5", 64'(fu_ready), 64'hF);
      if (c == 5) chk("bp_ready_e6", 64'(fu_ready), 64'b0011);
    end
    fu_valid  = 4'b0100;
    fu_pkt[2] = mk(2, 32'hB000_0206, 6, 1'b1);
    exp_d[2][wi[2]] = 32'hB000_0206;
    wi[2]++;
    tick();
    chk("bp_ready_e7", 64'(fu_ready), 64'hF);
    tick();
    chk("bp_ready_e8", 64'(fu_ready), 64'b1011);
    fu_valid = '0;
    for (int t = 0; t < 20; t++) begin
      if (outs == 25) break;
      @(negedge clk);
      #1;
    end
    chk("bp_total", 64'(outs), 64'd25);
    chk("bp_rr", 64'(dut.rr_ptr), 64'd3);
    chk("bp_ready_end", 64'(fu_ready), 64'hF);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback arbiter between the execution units (ALU, FPU, LSU, BRU, and any added later) and the register-file write ports / ROB writeback inputs of the backend. It replaces the fixed one-FU-per-write-port wiring: `NUM_FU` result producers share `NUM_WB_PORTS` registered write ports, and a per-FU skid FIFO absorbs contention. Grants rotate round-robin, so a unit stalls only through its own `fu_ready_out`. A flush discards every buffered result.

## Interface
Parameters:
- `NUM_FU`, 4, number of producing functional units (≥2)
- `NUM_WB_PORTS`, 2, number of write/writeback ports driven per cycle (1..`NUM_FU`)
- `FIFO_DEPTH`, 4, entries per FU skid FIFO (power of two, ≥2)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_in`  in  1  clock
- `rst_N_in`  in  1  asynchronous active-low reset
- `flush_in`  in  1  discard all buffered results (mispredict recovery)
- `fu_valid_in`  in  `NUM_FU`  FU i presents a result
- `fu_pkt_in`  in  `NUM_FU` × `wb_pkg::wb_req_t`  result: `dest_reg_phys`, `data` (`reg_pkg::WORD_SIZE`), `rob_ptr`, `has_dest`
- `fu_ready_out`  out  `NUM_FU`  FU i FIFO can accept this cycle
- `wr_valid_out`  out  `NUM_WB_PORTS`  port k carries a result
- `wr_en_out`  out  `NUM_WB_PORTS`  regfile write enable (= `wr_valid_out[k] & has_dest`)
- `wr_pkt_out`  out  `NUM_WB_PORTS` × `wb_pkg::wb_req_t`  granted result
- `wr_src_out`  out  `NUM_WB_PORTS` × `$clog2(NUM_FU)`  granting FU index (debug/ROB tagging)

## Operation
- Push: FU i pushes when `fu_valid_in[i] & fu_ready_out[i]`. The FIFO preserves per-FU order.
- `fu_ready_out[i]` = registered count(i) < `FIFO_DEPTH`. It is computed from the current count only, so a full FIFO deasserts ready even in a cycle where it also pops. This avoids a combinational ready path.
- Arbitration, each cycle:
  - Scan FUs from `rr_ptr` upward, modulo `NUM_FU`.
  - Grant each non-empty FIFO head in scan order until `NUM_WB_PORTS` grants are made or all FUs are visited.
  - An FU gets at most one grant per cycle. Grant n drives port n. Ports beyond the grant count drive valid=0.
- `rr_ptr` update: becomes (last granted index + 1) mod `NUM_FU`. It is unchanged when there are no grants.
- Granted heads pop the same cycle. Outputs are registered from the heads.
- Entries with `has_dest`=0 (stores, branches) still consume a port: `wr_valid_out`=1, `wr_en_out`=0.
- Flush: when `flush_in`=1 at a clock edge:
  - All counts and pointers go to 0 and `rr_ptr` goes to 0.
  - Same-cycle pushes are dropped. Next-cycle outputs are all invalid.
  - Flush wins over push and grant.
- Widths: FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Counts are `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values: `wr_valid_out`=0, `wr_en_out`=0, `wr_pkt_out`=0, `wr_src_out`=0, `rr_ptr`=0, all FIFOs empty, `fu_ready_out`=all ones.
- Latency: a result pushed at edge N can be granted at edge N+1 and is visible on the ports after edge N+1. The minimum is one cycle; there is no FIFO bypass.
- Throughput: at most `NUM_WB_PORTS` results per cycle in total, at most one per FU.
- Reset asserted mid-operation clears all state asynchronously. Buffered results are lost, and outputs go to 0 immediately.
- Push and pop in the same cycle on a non-full FIFO leave the count unchanged.

## Structure
- `wb_pkg`: `wb_req_t` (packed: `dest_reg_phys` [`$clog2(reg_pkg::NUM_PHYS_REGS)`], `data` [`reg_pkg::WORD_SIZE`], `rob_ptr` [`$clog2(rob_pkg::ROB_ENTRIES)`], `has_dest`).
- Sub-module `wb_skid_fifo`: single-clock, `FIFO_DEPTH`, with push/pop/count/head/flush. `wb_arbiter` instantiates `NUM_FU` copies.
- Round-robin multi-grant logic lives in `wb_arbiter` as a combinational loop over `NUM_FU`.

## Test plan
- Single result: FU0 pushes dest=5, data=0xAA, has_dest=1 at cycle 1 → port0 valid with dest 5, data 0xAA, `wr_en_out[0]`=1 after cycle 2; port1 invalid.
- Contention (4 FUs, 2 ports, `rr_ptr`=0): all four push once in the same cycle → next cycle FU0/FU1 drain on ports 0/1 and `rr_ptr`=2; the cycle after, FU2/FU3 drain and `rr_ptr`=0.
- Backpressure: FU2 pushes 5 results back-to-back while others starve FU2 of grants → `fu_ready_out[2]`=0 after 4 accepted; the 5th is held by the FU; no result is lost or reordered.
- Store result: `has_dest`=0 → `wr_valid_out`=1, `wr_en_out`=0, `rob_ptr` passed through.
- Flush: 3 entries buffered in FU1, then `flush_in` with a simultaneous FU0 push → next cycle all ports invalid, all FIFOs empty, `fu_ready_out`=1111.
- Reset: assert `rst_N_in`=0 asynchronously with entries buffered → outputs 0 without a clock edge; after release, the first push emerges normally.
